// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - run-control sequencer around a windowed up-counter with prescaler
// Commands arrive on a valid/ready port; a command always beats a same-cycle step.
module counter_sequencer #(
  parameter int WIDTH                = 8,
  parameter int CLOCKS_PER_INCREMENT = 1,
  parameter int MIN_VALUE            = 0,
  parameter int MAX_VALUE            = 5,
  parameter int PASS_WIDTH           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_min,
  input  logic [WIDTH-1:0]      cmd_max,
  input  logic [PASS_WIDTH-1:0] cmd_passes,
  output logic [WIDTH-1:0]      count,
  output logic [PASS_WIDTH-1:0] pass_count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  wrap,
  output logic                  done,
  output logic                  cmd_err
);

  localparam int PW = (CLOCKS_PER_INCREMENT > 1) ? $clog2(CLOCKS_PER_INCREMENT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCKS_PER_INCREMENT - 1);

  localparam logic [1:0] OP_CONFIG = 2'd0;
  localparam logic [1:0] OP_START  = 2'd1;
  localparam logic [1:0] OP_PAUSE  = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      cfg_min_q, cfg_min_d;
  logic [WIDTH-1:0]      cfg_max_q, cfg_max_d;
  logic [PASS_WIDTH-1:0] cfg_passes_q, cfg_passes_d;
  logic [PASS_WIDTH-1:0] pass_count_q, pass_count_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  busy_q, busy_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  cmd_ready_q, cmd_ready_d;

  logic                  accept;
  logic [PASS_WIDTH-1:0] pass_inc;

  assign accept   = cmd_valid && cmd_ready_q;
  assign pass_inc = (pass_count_q == {PASS_WIDTH{1'b1}}) ? pass_count_q
                                                         : pass_count_q + PASS_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    cfg_min_d    = cfg_min_q;
    cfg_max_d    = cfg_max_q;
    cfg_passes_d = cfg_passes_q;
    pass_count_d = pass_count_q;
    presc_d      = presc_q;
    wrap_d       = 1'b0;
    done_d       = 1'b0;
    cmd_err_d    = 1'b0;
    cmd_ready_d  = 1'b1;

    if (accept) begin
      case (cmd_op)
        OP_CONFIG: begin
          if ((state_q != S_IDLE && state_q != S_DONE) || (cmd_min > cmd_max)) begin
            cmd_err_d = 1'b1;
          end else begin
            cfg_min_d    = cmd_min;
            cfg_max_d    = cmd_max;
            cfg_passes_d = cmd_passes;
            count_d      = cmd_min;
          end
        end
        OP_START: begin
          count_d      = cfg_min_q;
          presc_d      = '0;
          pass_count_d = '0;
          state_d      = S_RUN;
        end
        OP_PAUSE: begin
          if (state_q == S_RUN)        state_d = S_PAUSE;
          else if (state_q == S_PAUSE) state_d = S_RUN;
          else                         cmd_err_d = 1'b1;
        end
        default: begin
          if (state_q == S_RUN || state_q == S_PAUSE) begin
            state_d = S_IDLE;
            count_d = cfg_min_q;
            presc_d = '0;
          end
        end
      endcase
    end else if (state_q == S_RUN) begin
      // A step only happens on an edge with no accepted command.
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (count_q < cfg_max_q) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          wrap_d       = 1'b1;
          pass_count_d = pass_inc;
          if (cfg_passes_q != '0 && pass_inc == cfg_passes_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            count_d = cfg_min_q;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= WIDTH'(MIN_VALUE);
      cfg_min_q    <= WIDTH'(MIN_VALUE);
      cfg_max_q    <= WIDTH'(MAX_VALUE);
      cfg_passes_q <= '0;
      pass_count_q <= '0;
      presc_q      <= '0;
      busy_q       <= 1'b0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      cfg_min_q    <= cfg_min_d;
      cfg_max_q    <= cfg_max_d;
      cfg_passes_q <= cfg_passes_d;
      pass_count_q <= pass_count_d;
      presc_q      <= presc_d;
      busy_q       <= busy_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
      cmd_err_q    <= cmd_err_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign count      = count_q;
  assign pass_count = pass_count_q;
  assign state      = state_q;
  assign busy       = busy_q;
  assign wrap       = wrap_q;
  assign done       = done_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - directed bench for counter_sequencer (CPI=1 and CPI=3 instances)
module tb_counter_sequencer;

  logic       clk;
  logic       rst;

  logic       a_valid, a_ready, a_wrap, a_done, a_err, a_busy;
  logic [1:0] a_op, a_state;
  logic [7:0] a_min, a_max, a_passes, a_count, a_pass;

  logic       b_valid, b_ready, b_wrap, b_done, b_err, b_busy;
  logic [1:0] b_op, b_state;
  logic [7:0] b_min, b_max, b_passes, b_count, b_pass;

  int n_cmp;
  int n_err;
  int exp_c[7];
  int exp_w[7];
  int exp_d[7];

  counter_sequencer #(.WIDTH(8), .CLOCKS_PER_INCREMENT(1), .MIN_VALUE(0),
                      .MAX_VALUE(5), .PASS_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op),
    .cmd_min(a_min), .cmd_max(a_max), .cmd_passes(a_passes), .count(a_count),
    .pass_count(a_pass), .state(a_state), .busy(a_busy), .wrap(a_wrap),
    .done(a_done), .cmd_err(a_err)
  );

  counter_sequencer #(.WIDTH(8), .CLOCKS_PER_INCREMENT(3), .MIN_VALUE(0),
                      .MAX_VALUE(5), .PASS_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
    .cmd_min(b_min), .cmd_max(b_max), .cmd_passes(b_passes), .count(b_count),
    .pass_count(b_pass), .state(b_state), .busy(b_busy), .wrap(b_wrap),
    .done(b_done), .cmd_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [1:0] op, input logic [7:0] mn,
                        input logic [7:0] mx, input logic [7:0] ps);
    a_valid = 1'b1; a_op = op; a_min = mn; a_max = mx; a_passes = ps;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] op);
    b_valid = 1'b1; b_op = op;
    tick();
    b_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a_valid = 1'b0; a_op = 2'd0; a_min = 8'd0; a_max = 8'd0; a_passes = 8'd0;
    b_valid = 1'b0; b_op = 2'd0; b_min = 8'd0; b_max = 8'd0; b_passes = 8'd0;
    tick();
    tick();

    // reset state
    chk("rst_count", a_count, 0);
    chk("rst_state", a_state, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_wrap", a_wrap, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_ready", a_ready, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", a_ready, 1);

    // default window, CPI=1
    send_a(2'd1, 0, 0, 0);
    chk("t1_start_count", a_count, 0);
    chk("t1_start_state", a_state, 1);
    chk("t1_busy", a_busy, 1);
    exp_c = '{1, 2, 3, 4, 5, 0, 1};
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("t1_count[%0d]", i), a_count, exp_c[i]);
      chk($sformatf("t1_wrap[%0d]", i), a_wrap, (exp_c[i] == 0) ? 1 : 0);
      chk($sformatf("t1_done[%0d]", i), a_done, 0);
    end

    // ABORT colliding with a step
    send_a(2'd3, 0, 0, 0);
    chk("abort_col_count", a_count, 0);
    chk("abort_col_state", a_state, 0);
    chk("abort_col_wrap", a_wrap, 0);
    chk("abort_col_pass", a_pass, 1);
    chk("abort_col_err", a_err, 0);

    // bounded run: min=2 max=4 passes=2
    send_a(2'd0, 2, 4, 2);
    chk("t2_cfg_count", a_count, 2);
    chk("t2_cfg_err", a_err, 0);
    send_a(2'd1, 0, 0, 0);
    chk("t2_start_count", a_count, 2);
    chk("t2_start_pass", a_pass, 0);
    exp_c = '{3, 4, 2, 3, 4, 4, 4};
    exp_w = '{0, 0, 1, 0, 0, 1, 0};
    exp_d = '{0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("t2_count[%0d]", i), a_count, exp_c[i]);
      chk($sformatf("t2_wrap[%0d]", i), a_wrap, exp_w[i]);
      chk($sformatf("t2_done[%0d]", i), a_done, exp_d[i]);
    end
    chk("t2_state", a_state, 3);
    chk("t2_pass", a_pass, 2);
    chk("t2_busy", a_busy, 0);

    // illegal commands
    send_a(2'd1, 0, 0, 0);
    send_a(2'd0, 0, 1, 0);
    chk("cfg_in_run_err", a_err, 1);
    chk("cfg_in_run_count", a_count, 2);
    chk("cfg_in_run_state", a_state, 1);
    tick();
    chk("cfg_in_run_err_clr", a_err, 0);
    chk("cfg_in_run_step", a_count, 3);
    send_a(2'd3, 0, 0, 0);
    chk("abort_run_count", a_count, 2);
    chk("abort_run_state", a_state, 0);
    send_a(2'd2, 0, 0, 0);
    chk("pause_idle_err", a_err, 1);
    chk("pause_idle_state", a_state, 0);
    tick();
    chk("pause_idle_err_clr", a_err, 0);
    send_a(2'd0, 7, 3, 0);
    chk("bad_cfg_err", a_err, 1);
    chk("bad_cfg_count", a_count, 2);
    chk("bad_cfg_state", a_state, 0);
    send_a(2'd3, 0, 0, 0);
    chk("abort_idle_err", a_err, 0);
    chk("abort_idle_state", a_state, 0);
    send_a(2'd1, 0, 0, 0);
    chk("cfg_kept_min", a_count, 2);
    tick();
    tick();
    tick();
    chk("cfg_kept_wrap", a_count, 2);
    chk("cfg_kept_wrap_pulse", a_wrap, 1);

    // START on the final step of a passes=1 run
    send_a(2'd3, 0, 0, 0);
    send_a(2'd0, 1, 2, 1);
    send_a(2'd1, 0, 0, 0);
    tick();
    chk("final_pre_count", a_count, 2);
    send_a(2'd1, 0, 0, 0);
    chk("final_col_count", a_count, 1);
    chk("final_col_state", a_state, 1);
    chk("final_col_done", a_done, 0);
    chk("final_col_wrap", a_wrap, 0);
    chk("final_col_pass", a_pass, 0);
    tick();
    chk("final_re_count", a_count, 2);
    tick();
    chk("final_done", a_done, 1);
    chk("final_state", a_state, 3);
    chk("final_hold", a_count, 2);
    chk("final_pass", a_pass, 1);

    // pause/resume with CPI=3, prescaler phase kept across pause
    send_b(2'd1);
    chk("p_start", b_count, 0);
    tick();
    tick();
    chk("p_pre1", b_count, 0);
    tick();
    chk("p_inc1", b_count, 1);
    tick();
    tick();
    chk("p_pre2", b_count, 1);
    tick();
    chk("p_inc2", b_count, 2);
    tick();
    send_b(2'd2);
    chk("p_paused_state", b_state, 2);
    chk("p_paused_busy", b_busy, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("p_frozen[%0d]", i), b_count, 2);
    end
    send_b(2'd2);
    chk("p_resume_state", b_state, 1);
    chk("p_resume_count", b_count, 2);
    tick();
    chk("p_tick2", b_count, 2);
    tick();
    chk("p_inc3", b_count, 3);

    // reset pulses during a run
    for (int k = 0; k < 4; k++) begin
      send_a(2'd1, 0, 0, 0);
      repeat ($urandom_range(6, 12)) tick();
      rst = 1'b1;
      tick();
      chk($sformatf("rr_count[%0d]", k), a_count, 0);
      chk($sformatf("rr_state[%0d]", k), a_state, 0);
      chk($sformatf("rr_ready[%0d]", k), a_ready, 0);
      chk($sformatf("rr_done[%0d]", k), a_done, 0);
      rst = 1'b0;
      tick();
      chk($sformatf("rr_ready_up[%0d]", k), a_ready, 1);
      chk($sformatf("rr_idle[%0d]", k), a_state, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run-control front end for the bounded up-counter datapath. It holds a programmable MIN..MAX window and a pass count, and applies start/pause/abort commands received over a valid/ready command port. It contains the count register and the increment prescaler, so it replaces a free-running counter wherever software or an upstream FSM must sequence counting runs.

Parameters:
WIDTH, 8, width of count and window bounds
CLOCKS_PER_INCREMENT, 1, clocks per count step (>=1)
MIN_VALUE, 0, reset value of the lower bound
MAX_VALUE, 5, reset value of the upper bound
PASS_WIDTH, 8, width of the pass-count fields

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=CONFIG, 1=START, 2=PAUSE (toggle), 3=ABORT
cmd_min  in  WIDTH  CONFIG lower bound
cmd_max  in  WIDTH  CONFIG upper bound
cmd_passes  in  PASS_WIDTH  CONFIG pass limit, 0=run forever
count  out  WIDTH  current count value
pass_count  out  PASS_WIDTH  passes completed in the current run
state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE
busy  out  1  state is RUN or PAUSE
wrap  out  1  1-cycle pulse on each pass completion
done  out  1  1-cycle pulse on entry to DONE
cmd_err  out  1  1-cycle pulse when an accepted command is rejected

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, count=MIN_VALUE, cfg_min=MIN_VALUE, cfg_max=MAX_VALUE, cfg_passes=0, pass_count=0. busy, wrap, done, cmd_err and cmd_ready all 0. cmd_ready goes to 1 on the first edge with rst=0 and stays 1. Reset mid-run aborts immediately; no done pulse.
- Every command with valid&ready is consumed in that cycle. Illegal commands are consumed, have no effect, and pulse cmd_err on the next cycle.
- CONFIG: legal in IDLE or DONE only. If cmd_min>cmd_max, it is rejected (cmd_err) and the config is unchanged. Otherwise it latches min, max and passes, and sets count=cmd_min. State is unchanged (DONE stays DONE).
- START: legal in any state. It sets count=cfg_min, clears the prescaler and pass_count, and enters RUN. In RUN or PAUSE it restarts the run.
- PAUSE: RUN->PAUSE and PAUSE->RUN. Count and prescaler are frozen in PAUSE, and resume keeps the prescaler phase. In IDLE or DONE it is rejected (cmd_err).
- ABORT: RUN or PAUSE -> IDLE with count=cfg_min and pass_count held. In IDLE or DONE it is a silent no-op.
- Step: in RUN the prescaler counts 0..CLOCKS_PER_INCREMENT-1, and a step fires on the edge where it equals CLOCKS_PER_INCREMENT-1. The first step comes CLOCKS_PER_INCREMENT edges after START is accepted.
- Step when count<cfg_max: count+1.
- Step when count==cfg_max (pass complete): wrap=1 next cycle and pass_count+1 (saturating).
  - If cfg_passes!=0 and the new pass_count==cfg_passes: count holds cfg_max, state becomes DONE, done=1.
  - Otherwise count=cfg_min.
- When cfg_min==cfg_max, every step is a pass completion and count stays constant.
- Simultaneous accepted command and step: the command wins and the step is discarded, including a final step.
- Arithmetic is unsigned, WIDTH bits. Increment never overflows because count<=cfg_max always.
- All outputs are registered.

Test Plan:
- Reset with defaults, then START, CPI=1: count 0,1,2,3,4,5,0,1 on successive cycles; wrap pulses on the cycle count returns to 0; busy=1; done never asserts.
- CONFIG min=2 max=4 passes=2, then START: count 2,3,4,2,3,4 then holds 4. wrap pulses twice; done pulses once with state=DONE, pass_count=2, busy=0.
- CPI=3, START, PAUSE after the 2nd increment, wait 10 cycles, PAUSE again: count frozen at MIN+2 for 10 cycles; the next increment comes exactly 3 prescaler ticks after the 2nd, counting ticks before pause and after resume.
- Illegal commands: CONFIG while RUN, PAUSE in IDLE, CONFIG min=7 max=3 in IDLE. Each gives a 1-cycle cmd_err, no state change, config unchanged; ABORT in IDLE gives no cmd_err.
- Collisions: ABORT on the same cycle as a step leaves count=cfg_min and state=IDLE with no wrap. START on the final step of a passes=1 run gives no done, restarts at cfg_min and clears pass_count.
- Random rst pulses (60–120 ns apart) during RUN: the cycle after each rst has count==MIN_VALUE, state=IDLE, cmd_ready=0, then cmd_ready=1 on the first cycle after rst falls.
